// File: rtl/power_peak_detect.sv
// Per-frame peak detector for the squared-magnitude power stream.
// Tracks the maximum power and its bin over each tlast-delimited frame and
// emits one 64-bit result beat per frame: {peak index, hit count, peak power}.
// Optional feature macro: PEAK_THRESH_COUNT_EN builds the threshold comparator
// and the 16-bit hit counter; without it the hit field is constant zero.
module power_peak_detect #(
    parameter int INDEX_WIDTH = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [31:0]            threshold,
    input  logic [31:0]            s_axis_data_tdata,
    input  logic                   s_axis_data_tvalid,
    output logic                   s_axis_data_tready,
    input  logic                   s_axis_data_tlast,
    input  logic [INDEX_WIDTH-1:0] xk_in,
    output logic [63:0]            m_axis_peak_tdata,
    output logic                   m_axis_peak_tvalid,
    input  logic                   m_axis_peak_tready,
    output logic                   m_axis_peak_tlast,
    output logic                   frame_overflow,
    output logic [15:0]            frames_dropped
);

    localparam int DATA_W = 32;

    typedef enum logic {ACC_IDLE, ACC_RUN} acc_state_t;
    typedef enum logic {OUT_EMPTY, OUT_FULL} out_state_t;

    acc_state_t             acc_q, acc_d;
    out_state_t             out_q, out_d;
    logic [DATA_W-1:0]      max_q, max_d;
    logic [INDEX_WIDTH-1:0] idx_q, idx_d;
    logic [15:0]            hits_d;
    logic [63:0]            res_q, res_d;
    logic                   ovf_q, ovf_d;
    logic [15:0]            drop_q, drop_d;
    logic                   beat;
    logic                   frame_done;

    // Saturating 16-bit increment shared by the hit and drop counters.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign beat = s_axis_data_tvalid & ~rst;

`ifdef PEAK_THRESH_COUNT_EN
    logic [15:0] hits_q;
    logic        hit;
    assign hit = (s_axis_data_tdata >= threshold);
`else
    logic unused_threshold;
    assign unused_threshold = ^threshold;
`endif

    // Accumulator FSM: first beat of a frame loads, later beats compare.
    always_comb begin
        acc_d      = acc_q;
        max_d      = max_q;
        idx_d      = idx_q;
        frame_done = 1'b0;
`ifdef PEAK_THRESH_COUNT_EN
        hits_d     = hits_q;
`else
        hits_d     = 16'd0;
`endif
        if (beat) begin
            frame_done = s_axis_data_tlast;
            if (acc_q == ACC_IDLE) begin
                max_d = s_axis_data_tdata;
                idx_d = xk_in;
`ifdef PEAK_THRESH_COUNT_EN
                hits_d = hit ? 16'd1 : 16'd0;
`endif
            end else begin
                // Strict compare so that ties keep the earlier bin.
                if (s_axis_data_tdata > max_q) begin
                    max_d = s_axis_data_tdata;
                    idx_d = xk_in;
                end
`ifdef PEAK_THRESH_COUNT_EN
                if (hit) begin
                    hits_d = sat_inc16(hits_q);
                end
`endif
            end
            acc_d = s_axis_data_tlast ? ACC_IDLE : ACC_RUN;
        end
    end

    // Output holding register: load, replace-on-accept, or drop when blocked.
    always_comb begin
        out_d  = out_q;
        res_d  = res_q;
        ovf_d  = ovf_q;
        drop_d = drop_q;
        if (frame_done) begin
            if ((out_q == OUT_EMPTY) || m_axis_peak_tready) begin
                res_d = {16'(idx_d), hits_d, max_d};
                out_d = OUT_FULL;
            end else begin
                ovf_d  = 1'b1;
                drop_d = sat_inc16(drop_q);
            end
        end else if ((out_q == OUT_FULL) && m_axis_peak_tready) begin
            out_d = OUT_EMPTY;
        end
    end

    // State and data registers; reset discards any partial frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q  <= ACC_IDLE;
            max_q  <= '0;
            idx_q  <= '0;
`ifdef PEAK_THRESH_COUNT_EN
            hits_q <= '0;
`endif
            out_q  <= OUT_EMPTY;
            res_q  <= '0;
            ovf_q  <= 1'b0;
            drop_q <= '0;
        end else begin
            acc_q  <= acc_d;
            max_q  <= max_d;
            idx_q  <= idx_d;
`ifdef PEAK_THRESH_COUNT_EN
            hits_q <= hits_d;
`endif
            out_q  <= out_d;
            res_q  <= res_d;
            ovf_q  <= ovf_d;
            drop_q <= drop_d;
        end
    end

    assign s_axis_data_tready = ~rst;
    assign m_axis_peak_tdata  = res_q;
    assign m_axis_peak_tvalid = (out_q == OUT_FULL);
    assign m_axis_peak_tlast  = (out_q == OUT_FULL);
    assign frame_overflow     = ovf_q;
    assign frames_dropped     = drop_q;

endmodule

// File: tb/tb_power_peak_detect.sv
// Scoreboard bench for power_peak_detect: expected results are queued when
// frames are driven and compared when the DUT hands a result downstream.
module tb_power_peak_detect;

`ifdef PEAK_THRESH_COUNT_EN
    localparam bit HIT_EN = 1'b1;
`else
    localparam bit HIT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] threshold = 32'd0;
    logic [31:0] s_tdata = 32'd0;
    logic        s_tvalid = 1'b0;
    logic        s_tready;
    logic        s_tlast = 1'b0;
    logic [9:0]  xk = 10'd0;
    logic [63:0] m_tdata;
    logic        m_tvalid;
    logic        m_tready = 1'b1;
    logic        m_tlast;
    logic        ovf;
    logic [15:0] dropped;

    int errors = 0;
    int checks = 0;
    logic [63:0] sb[$];

    int pw1[8] = '{5, 9, 3, 9, 1, 0, 2, 7};

    power_peak_detect #(.INDEX_WIDTH(10)) dut (
        .clk(clk), .rst(rst), .threshold(threshold),
        .s_axis_data_tdata(s_tdata), .s_axis_data_tvalid(s_tvalid),
        .s_axis_data_tready(s_tready), .s_axis_data_tlast(s_tlast),
        .xk_in(xk),
        .m_axis_peak_tdata(m_tdata), .m_axis_peak_tvalid(m_tvalid),
        .m_axis_peak_tready(m_tready), .m_axis_peak_tlast(m_tlast),
        .frame_overflow(ovf), .frames_dropped(dropped)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [15:0] hx(input int n);
        return HIT_EN ? 16'(n) : 16'd0;
    endfunction

    function automatic logic [63:0] mk(input int idx, input logic [15:0] hits, input logic [31:0] p);
        return {16'(idx), hits, p};
    endfunction

    task automatic send(input logic [31:0] p, input int k, input logic last);
        s_tdata  = p;
        xk       = 10'(k);
        s_tlast  = last;
        s_tvalid = 1'b1;
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    // Downstream side: every accepted result is matched against the queue.
    always @(negedge clk) begin
        if (!rst && m_tvalid && m_tready) begin
            if (sb.size() == 0) begin
                chk("unexpected_result", 64'd1, 64'd0);
            end else begin
                chk("result", m_tdata, sb.pop_front());
                chk("tlast", 64'(m_tlast), 64'd1);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        // Reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tvalid", 64'(m_tvalid), 64'd0);
        chk("rst_tlast", 64'(m_tlast), 64'd0);
        chk("rst_tdata", m_tdata, 64'd0);
        chk("rst_ovf", 64'(ovf), 64'd0);
        chk("rst_dropped", 64'(dropped), 64'd0);
        chk("rst_s_tready", 64'(s_tready), 64'd0);
        rst = 1'b0;
        #1;
        chk("s_tready", 64'(s_tready), 64'd1);

        // 8-bin frame, tie keeps the first bin
        threshold = 32'd7;
        m_tready  = 1'b1;
        n = 0;
        for (int i = 0; i < 8; i++) if (pw1[i] >= 7) n++;
        sb.push_back(mk(1, hx(n), 32'd9));
        for (int i = 0; i < 8; i++) begin
            send(32'(pw1[i]), i, (i == 7));
            if (i == 6) chk("pre_last_tvalid", 64'(m_tvalid), 64'd0);
        end
        chk("latency_tvalid", 64'(m_tvalid), 64'd1);

        // Back-to-back single-beat frames
        threshold = 32'd12;
        for (int i = 0; i < 8; i++) begin
            sb.push_back(mk(i, hx((10 + i >= 12) ? 1 : 0), 32'(10 + i)));
        end
        for (int i = 0; i < 8; i++) begin
            send(32'(10 + i), i, 1'b1);
            chk("b2b_tvalid", 64'(m_tvalid), 64'd1);
        end
        @(posedge clk);
        #1;
        chk("b2b_dropped", 64'(dropped), 64'd0);
        chk("b2b_drained", 64'(sb.size()), 64'd0);

        // Blocked downstream: first held, second dropped
        m_tready  = 1'b0;
        threshold = 32'd25;
        send(32'd20, 0, 1'b0);
        send(32'd40, 1, 1'b0);
        send(32'd30, 2, 1'b0);
        send(32'd10, 3, 1'b1);
        chk("hold_tvalid", 64'(m_tvalid), 64'd1);
        chk("hold_data", m_tdata, mk(1, hx(2), 32'd40));
        send(32'd50, 4, 1'b0);
        send(32'd60, 5, 1'b0);
        send(32'd70, 6, 1'b0);
        chk("pre_drop_ovf", 64'(ovf), 64'd0);
        send(32'd80, 7, 1'b1);
        chk("drop_data", m_tdata, mk(1, hx(2), 32'd40));
        chk("drop_ovf", 64'(ovf), 64'd1);
        chk("drop_count", 64'(dropped), 64'd1);
        sb.push_back(mk(1, hx(2), 32'd40));
        m_tready = 1'b1;
        @(posedge clk);
        #1;
        chk("accept_tvalid", 64'(m_tvalid), 64'd0);

        // Completion coinciding with acceptance of the held result
        m_tready  = 1'b0;
        threshold = 32'd0;
        send(32'd7, 5, 1'b0);
        send(32'd3, 6, 1'b1);
        chk("full_tvalid", 64'(m_tvalid), 64'd1);
        send(32'd1, 8, 1'b0);
        sb.push_back(mk(5, hx(2), 32'd7));
        sb.push_back(mk(9, hx(2), 32'd2));
        m_tready = 1'b1;
        send(32'd2, 9, 1'b1);
        chk("swap_data", m_tdata, mk(9, hx(2), 32'd2));
        chk("swap_tvalid", 64'(m_tvalid), 64'd1);
        chk("swap_dropped", 64'(dropped), 64'd1);
        @(posedge clk);
        #1;
        chk("swap_empty", 64'(m_tvalid), 64'd0);

        // Reset in the middle of a frame
        threshold = 32'd5;
        send(32'd30, 0, 1'b0);
        send(32'd40, 1, 1'b0);
        send(32'd100, 2, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_tdata", m_tdata, 64'd0);
        chk("midrst_ovf", 64'(ovf), 64'd0);
        chk("midrst_dropped", 64'(dropped), 64'd0);
        chk("midrst_s_tready", 64'(s_tready), 64'd0);
        rst = 1'b0;
        sb.push_back(mk(4, hx(1), 32'd6));
        send(32'd4, 3, 1'b0);
        send(32'd6, 4, 1'b1);
        chk("post_rst_data", m_tdata, mk(4, hx(1), 32'd6));

        // Largest upstream power against zero, threshold zero
        threshold = 32'd0;
        sb.push_back(mk(10, hx(2), 32'h7FFF_FFFF));
        send(32'h7FFF_FFFF, 10, 1'b0);
        send(32'd0, 11, 1'b1);
        chk("max_power", 64'(m_tdata[31:0]), 64'h7FFF_FFFF);
        chk("hits_field", 64'(m_tdata[47:32]), 64'(hx(2)));

        // Drain whatever is still outstanding
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
        #1;
        chk("drain", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
